icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge) and rst (reset_status_t; asserted low, takes effect immediately without a clock edge).
REQ-002 Port clk  input  1  system clock.
REQ-003 Port rst  input  1  asynchronous active-low reset.
REQ-004 Port rom_ce_i  input  chip_status_t  fetch enable from pc stage.
REQ-005 Port rom_addr_i  input  inst_addr_t (32)  fetch byte address.
REQ-006 Port rom_data_o  output  inst_t (32)  instruction to if_id.
REQ-007 Port stallreq_o  output  1  fetch stall request to ctrl.
REQ-008 Port flush_i  input  1  invalidate all lines.
REQ-009 Port mem_req_o  output  1  external word-read request.
REQ-010 Port mem_addr_o  output  32  external word address (bits[1:0]=0).
REQ-011 Port mem_ack_i  input  1  external read complete; mem_data_i valid this cycle.
REQ-012 Port mem_data_i  input  32  external read data.

Function
REQ-013 Organisation SHALL be direct-mapped, 64 lines x 4 words (1 KiB); address split tag[31:10], index[9:4], word[3:2], byte[1:0] ignored.
REQ-014 Per line state SHALL be valid bit, 22-bit tag, 4 x 32-bit data words.
REQ-015 FSM states SHALL be IDLE, REFILL, DONE.
REQ-016 IDLE, rom_ce_i disabled: rom_data_o=0, stallreq_o=0, no state change.
REQ-017 IDLE, rom_ce_i enabled, hit (valid and tag match): rom_data_o = selected word combinationally in the same cycle, stallreq_o=0 (zero-latency, matching a combinational ROM).
REQ-018 IDLE, enabled, miss: stallreq_o=1 combinationally same cycle; next edge latches tag/index, clears word counter, enters REFILL.
REQ-019 REFILL: mem_req_o=1, mem_addr_o={latched tag, latched index, counter, 2'b00}; req and addr SHALL stay stable until mem_ack_i sampled high.
REQ-020 On each edge with mem_ack_i=1 in REFILL: write mem_data_i into latched line at counter, increment 2-bit counter; after word 3 set tag, valid=1, go DONE.
REQ-021 mem_ack_i SHALL be ignored outside REFILL; mem_req_o=0 outside REFILL.
REQ-022 Fill order SHALL be word 0..3 regardless of requested word; counter wraps 3->0.
REQ-023 stallreq_o SHALL be 1 throughout REFILL; DONE SHALL drive rom_data_o from the filled line, stallreq_o=0, return to IDLE next edge (miss penalty = 4 ack cycles + 2).
REQ-024 rom_addr_i changes during REFILL SHALL not affect the refill (latched address used).
REQ-025 flush_i in IDLE/DONE SHALL clear all valid bits at next edge; a hit lookup in that same cycle still returns the pre-flush result.
REQ-026 flush_i during REFILL SHALL clear all valid bits; the refill completes and delivers data in DONE, and flush arriving on the final-ack edge wins (line left invalid).

Reset
REQ-027 rst low SHALL immediately force state IDLE, counter 0, all valid bits 0, mem_req_o=0, stallreq_o=0, rom_data_o=0; data/tag arrays need no reset.
REQ-028 Reset mid-REFILL SHALL abandon the refill with no line marked valid; a late mem_ack_i after reset SHALL be ignored.

Structure
REQ-029 Line/index/tag widths, ICACHE_LINES, ICACHE_WORDS and the FSM state enum SHALL live in project_types.
REQ-030 One sub-module icache_ram (data+tag array, one write port, one async read port) SHALL be used; valid bits stay in icache as flops.

Verification
REQ-031 Cold miss: fetch 0x0000_0100, ack each word after 1 cycle with 0xA0..0xA3 -> 4 mem_req_o words 0x100,0x104,0x108,0x10C; stallreq_o high until DONE; rom_data_o=0xA0.
REQ-032 Hit: then fetch 0x0000_0108 -> rom_data_o=0xA2 same cycle, stallreq_o=0, mem_req_o=0.
REQ-033 Conflict: fetch 0x0000_0500 (same index, tag 1) -> refill; then 0x0000_0100 misses again.
REQ-034 Ack backpressure: hold mem_ack_i low 5 cycles on word 2 -> mem_addr_o stable at 0x108, counter unchanged.
REQ-035 Flush on final-ack edge -> DONE returns data, next fetch of same address misses.
REQ-036 rst low mid-REFILL after word 1 -> outputs 0 immediately; refetch of same address misses and refills from word 0.

Source files
------------

// File: rtl/project_types.sv
// Shared types, geometry and FSM encoding for the instruction cache.
// Address split: tag[31:10], index[9:4], word[3:2]; byte offset is ignored.
package project_types;

  localparam int ICACHE_LINES = 64;
  localparam int ICACHE_WORDS = 4;
  localparam int INDEX_W      = 6;
  localparam int WORD_W       = 2;
  localparam int TAG_W        = 22;

  typedef logic [31:0]        inst_addr_t;
  typedef logic [31:0]        inst_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [WORD_W-1:0]  word_sel_t;

  typedef logic chip_status_t;
  typedef logic reset_status_t;

  localparam chip_status_t  CHIP_ENABLE  = 1'b1;
  localparam chip_status_t  CHIP_DISABLE = 1'b0;
  localparam reset_status_t RST_ENABLE   = 1'b0;
  localparam reset_status_t RST_DISABLE  = 1'b1;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_DONE   = 2'd2
  } icache_state_t;

  function automatic tag_t addr_tag(input inst_addr_t a);
    return a[31:10];
  endfunction

  function automatic index_t addr_index(input inst_addr_t a);
    return a[9:4];
  endfunction

  function automatic word_sel_t addr_word(input inst_addr_t a);
    return a[3:2];
  endfunction

endpackage

// File: rtl/icache_ram.sv
// Data and tag storage for the instruction cache: one synchronous write port,
// one asynchronous read port. Contents are not reset; validity lives in icache.
module icache_ram
  import project_types::*;
(
  input  logic      clk,
  input  logic      we_i,
  input  logic      tag_we_i,
  input  index_t    w_index_i,
  input  word_sel_t w_word_i,
  input  inst_t     w_data_i,
  input  tag_t      w_tag_i,
  input  index_t    r_index_i,
  input  word_sel_t r_word_i,
  output inst_t     r_data_o,
  output tag_t      r_tag_o
);

  inst_t data_mem_q [ICACHE_LINES][ICACHE_WORDS];
  tag_t  tag_mem_q  [ICACHE_LINES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      data_mem_q[w_index_i][w_word_i] <= w_data_i;
    end
    if (tag_we_i) begin
      tag_mem_q[w_index_i] <= w_tag_i;
    end
  end

  assign r_data_o = data_mem_q[r_index_i][r_word_i];
  assign r_tag_o  = tag_mem_q[r_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped 1 KiB instruction cache with zero-latency hits and a
// word-serial refill (words 0..3) from an external read port.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IC_IDLE   | lookup on rom_addr_i; hit returns data, miss latches address
// IC_REFILL | request words 0..3 of the latched line, one per mem_ack_i
// IC_DONE   | deliver requested word from freshly filled line, back to idle
module icache
  import project_types::*;
(
  input  logic          clk,
  input  reset_status_t rst,
  input  chip_status_t  rom_ce_i,
  input  inst_addr_t    rom_addr_i,
  output inst_t         rom_data_o,
  output logic          stallreq_o,
  input  logic          flush_i,
  output logic          mem_req_o,
  output logic [31:0]   mem_addr_o,
  input  logic          mem_ack_i,
  input  logic [31:0]   mem_data_i
);

  icache_state_t           state_q, state_d;
  tag_t                    tag_q, tag_d;
  index_t                  index_q, index_d;
  word_sel_t               word_q, word_d;
  word_sel_t               cnt_q, cnt_d;
  logic [ICACHE_LINES-1:0] valid_q, valid_d;

  logic      ram_we;
  logic      ram_tag_we;
  index_t    rd_index;
  word_sel_t rd_word;
  inst_t     rd_data;
  tag_t      rd_tag;
  logic      hit;
  logic      unused_byte;

  assign unused_byte = ^rom_addr_i[1:0];

  icache_ram u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .tag_we_i  (ram_tag_we),
    .w_index_i (index_q),
    .w_word_i  (cnt_q),
    .w_data_i  (mem_data_i),
    .w_tag_i   (tag_q),
    .r_index_i (rd_index),
    .r_word_i  (rd_word),
    .r_data_o  (rd_data),
    .r_tag_o   (rd_tag)
  );

  // Outside idle the read port follows the latched address, so rom_addr_i
  // wandering during a refill cannot disturb what DONE delivers.
  assign rd_index = (state_q == IC_IDLE) ? addr_index(rom_addr_i) : index_q;
  assign rd_word  = (state_q == IC_IDLE) ? addr_word(rom_addr_i)  : word_q;
  assign hit      = valid_q[rd_index] && (rd_tag == addr_tag(rom_addr_i));

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= IC_IDLE;
      tag_q   <= '0;
      index_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    index_d    = index_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    ram_we     = 1'b0;
    ram_tag_we = 1'b0;
    rom_data_o = '0;
    stallreq_o = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;

    unique case (state_q)
      IC_IDLE: begin
        if (rom_ce_i == CHIP_ENABLE) begin
          if (hit) begin
            rom_data_o = rd_data;
          end else begin
            stallreq_o = 1'b1;
            tag_d      = addr_tag(rom_addr_i);
            index_d    = addr_index(rom_addr_i);
            word_d     = addr_word(rom_addr_i);
            cnt_d      = '0;
            state_d    = IC_REFILL;
          end
        end
      end
      IC_REFILL: begin
        stallreq_o = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {tag_q, index_q, cnt_q, 2'b00};
        if (mem_ack_i) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            ram_tag_we       = 1'b1;
            valid_d[index_q] = 1'b1;
            state_d          = IC_DONE;
          end
        end
      end
      IC_DONE: begin
        rom_data_o = rd_data;
        state_d    = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase

    // A flush overrides a line being marked valid on the same edge.
    if (flush_i) begin
      valid_d = '0;
    end

    if (rst == RST_ENABLE) begin
      rom_data_o = '0;
      stallreq_o = 1'b0;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed scenarios plus random fetches checked
// against an abstract valid/tag model and a fixed external memory image.
module tb_icache;
  import project_types::*;

  logic          clk = 1'b0;
  reset_status_t rst;
  chip_status_t  rom_ce_i;
  inst_addr_t    rom_addr_i;
  inst_t         rom_data_o;
  logic          stallreq_o;
  logic          flush_i;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_ack_i;
  logic [31:0]   mem_data_i;

  logic flush_drv = 1'b0;
  logic flush_resp = 1'b0;
  assign flush_i = flush_drv | flush_resp;

  always #5 clk = ~clk;

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .stallreq_o (stallreq_o),
    .flush_i    (flush_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i)
  );

  typedef struct {
    inst_addr_t addr;
    inst_t      data;
    bit         hit;
    int         stall;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [31:0] mem_exp_q[$];
  bit          ref_valid [64];
  logic [21:0] ref_tag [64];
  int          ack_delay [4];
  bit          flush_on_last = 1'b0;
  bit          late_ack = 1'b0;
  int          stall_cnt = 0;
  int          waited = 0;
  exp_t        mon_e;

  function automatic logic [31:0] ext_mem(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + {28'd0, a[3:0]} / 4;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: one delivery per fetch, whenever the fetch is enabled and not stalled.
  always @(negedge clk) begin
    if (rst == RST_DISABLE) begin
      if (rom_ce_i != CHIP_ENABLE) begin
        check("disabled_data", rom_data_o, 32'd0);
        check("disabled_stall", {31'd0, stallreq_o}, 32'd0);
        stall_cnt = 0;
      end else if (stallreq_o) begin
        stall_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery: got %h want none", rom_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("rom_data", rom_data_o, mon_e.data);
          check("stall_cycles", stall_cnt, mon_e.stall);
          if (mon_e.hit) check("hit_mem_req", {31'd0, mem_req_o}, 32'd0);
        end
        stall_cnt = 0;
      end
    end else begin
      stall_cnt = 0;
    end
  end

  // External memory responder: acks after ack_delay[word] waiting cycles.
  always @(negedge clk) begin
    mem_ack_i  = late_ack;
    mem_data_i = late_ack ? 32'hDEAD_BEEF : 32'd0;
    flush_resp = 1'b0;
    if (rst == RST_DISABLE && mem_req_o) begin
      if (mem_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_mem_req: got addr %h want no request", mem_addr_o);
      end else begin
        check("mem_addr", mem_addr_o, mem_exp_q[0]);
        if (waited < ack_delay[mem_exp_q[0][3:2]]) begin
          waited++;
        end else begin
          mem_ack_i  = 1'b1;
          mem_data_i = ext_mem(mem_exp_q[0]);
          if (mem_exp_q[0][3:2] == 2'd3 && flush_on_last) flush_resp = 1'b1;
          void'(mem_exp_q.pop_front());
          waited = 0;
        end
      end
    end else begin
      waited = 0;
    end
  end

  function automatic bit model_hit(input inst_addr_t a);
    return ref_valid[a[9:4]] && (ref_tag[a[9:4]] == a[31:10]);
  endfunction

  task automatic fetch(input inst_addr_t a, input bit wiggle);
    exp_t e;
    int   idx = int'(a[9:4]);
    int   guard = 0;
    int   sum = 0;
    for (int w = 0; w < 4; w++) sum += ack_delay[w];
    e.addr  = a;
    e.data  = ext_mem({a[31:2], 2'b00});
    e.hit   = model_hit(a);
    e.stall = e.hit ? 0 : 5 + sum;
    exp_q.push_back(e);
    if (!e.hit) begin
      for (int w = 0; w < 4; w++) mem_exp_q.push_back({a[31:4], w[1:0], 2'b00});
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[31:10];
      if (flush_on_last) ref_valid = '{default: 1'b0};
    end
    rom_addr_i = a;
    rom_ce_i   = CHIP_ENABLE;
    @(negedge clk);
    while (stallreq_o && guard < 200) begin
      guard++;
      if (wiggle && guard > 1) rom_addr_i = $urandom;
      @(negedge clk);
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: got no delivery for %h want delivery", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_with_flush(input inst_addr_t a);
    flush_drv = 1'b1;
    fetch(a, 1'b0);
    flush_drv = 1'b0;
    ref_valid = '{default: 1'b0};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    inst_addr_t a;
    rst        = RST_ENABLE;
    rom_ce_i   = CHIP_ENABLE;
    rom_addr_i = 32'h100;
    ack_delay  = '{1, 1, 1, 1};
    ref_valid  = '{default: 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {31'd0, stallreq_o}, 32'd0);
    check("reset_data", rom_data_o, 32'd0);
    check("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
    rom_ce_i = CHIP_DISABLE;
    rst      = RST_DISABLE;
    @(posedge clk);
    #1;

    // Cold miss, then same-cycle hit on word 2 of the filled line.
    fetch(32'h0000_0100, 1'b0);
    rom_addr_i = 32'h0000_0108;
    rom_ce_i   = CHIP_ENABLE;
    #1;
    check("hit_comb_data", rom_data_o, 32'hA2);
    check("hit_comb_stall", {31'd0, stallreq_o}, 32'd0);
    check("hit_comb_mem_req", {31'd0, mem_req_o}, 32'd0);
    fetch(32'h0000_0108, 1'b0);

    // Conflict on index 16, then the evicted line misses again.
    fetch(32'h0000_0500, 1'b0);
    fetch(32'h0000_0100, 1'b0);

    // Backpressure on word 2: address held at 0x108 while ack stays low.
    fetch(32'h0000_0500, 1'b0);
    ack_delay = '{0, 0, 5, 0};
    fetch(32'h0000_0104, 1'b0);
    ack_delay = '{1, 1, 1, 1};

    // Flush on the final-ack edge: data delivered, line left invalid.
    flush_on_last = 1'b1;
    fetch(32'h0000_0500, 1'b0);
    flush_on_last = 1'b0;
    fetch(32'h0000_0500, 1'b0);

    // Flush in idle alongside a hit: hit still served, next lookup misses.
    fetch_with_flush(32'h0000_050C);
    fetch(32'h0000_050C, 1'b0);

    // Reset after word 1 of a refill, late ack, then refetch from word 0.
    for (int w = 0; w < 4; w++) mem_exp_q.push_back(32'h300 + 32'(w * 4));
    rom_addr_i = 32'h0000_0304;
    rom_ce_i   = CHIP_ENABLE;
    guard = 0;
    while (mem_exp_q.size() != 2 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL reset_setup_timeout: got %0d pending want 2", mem_exp_q.size());
    end
    @(posedge clk);
    #1;
    rst = RST_ENABLE;
    #1;
    check("rst_mid_stall", {31'd0, stallreq_o}, 32'd0);
    check("rst_mid_data", rom_data_o, 32'd0);
    check("rst_mid_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mid_mem_addr", mem_addr_o, 32'd0);
    mem_exp_q.delete();
    ref_valid = '{default: 1'b0};
    rom_ce_i  = CHIP_DISABLE;
    late_ack  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = RST_DISABLE;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    @(posedge clk);
    #1;
    check("late_ack_mem_req", {31'd0, mem_req_o}, 32'd0);
    fetch(32'h0000_0304, 1'b0);

    // Random traffic over a small address window to mix hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(3, 0) * 1024 + $urandom_range(7, 0) * 16 +
              $urandom_range(3, 0) * 4 + $urandom_range(3, 0));
      for (int w = 0; w < 4; w++) ack_delay[w] = $urandom_range(3, 0);
      if ($urandom_range(7, 0) == 0) begin
        rom_ce_i = CHIP_DISABLE;
        @(posedge clk);
        #1;
      end
      if (model_hit(a) && $urandom_range(9, 0) == 0) begin
        fetch_with_flush(a);
      end else begin
        flush_on_last = ($urandom_range(9, 0) == 0);
        fetch(a, $urandom_range(3, 0) == 0);
        flush_on_last = 1'b0;
      end
    end

    rom_ce_i = CHIP_DISABLE;
    repeat (3) @(posedge clk);
    #1;
    check("exp_queue_drained", exp_q.size(), 32'd0);
    check("mem_queue_drained", mem_exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
